// File: rtl/ps2_cmd_arbiter_if.sv
// ---------------------------------------------------------------------------
// ps2_cmd_arbiter_if
// Bundles the requester handshakes, the PS/2 shifter byte link and the
// completion report of ps2_cmd_arbiter.
//   slave  : the arbiter side (consumes requests / rx, drives tx / done)
//   master : the environment side (requesters, shifter, device model)
// ---------------------------------------------------------------------------
interface ps2_cmd_arbiter_if;
    // requester 0
    logic        req0_valid;
    logic [7:0]  req0_cmd;
    logic [7:0]  req0_arg;
    logic        req0_has_arg;
    logic [1:0]  req0_rxlen;
    logic        req0_ready;
    // requester 1
    logic        req1_valid;
    logic [7:0]  req1_cmd;
    logic [7:0]  req1_arg;
    logic        req1_has_arg;
    logic [1:0]  req1_rxlen;
    logic        req1_ready;
    // PS/2 byte shifter link
    logic        tx_start;
    logic [7:0]  tx_byte;
    logic        tx_done;
    logic        rx_valid;
    logic [7:0]  rx_byte;
    logic        rx_owned;
    // status / completion
    logic        busy;
    logic        done;
    logic        done_id;
    logic        err;
    logic [1:0]  err_code;
    logic [23:0] resp;

    modport slave (
        input  req0_valid, req0_cmd, req0_arg, req0_has_arg, req0_rxlen,
        input  req1_valid, req1_cmd, req1_arg, req1_has_arg, req1_rxlen,
        input  tx_done, rx_valid, rx_byte,
        output req0_ready, req1_ready,
        output tx_start, tx_byte, rx_owned,
        output busy, done, done_id, err, err_code, resp
    );

    modport master (
        output req0_valid, req0_cmd, req0_arg, req0_has_arg, req0_rxlen,
        output req1_valid, req1_cmd, req1_arg, req1_has_arg, req1_rxlen,
        output tx_done, rx_valid, rx_byte,
        input  req0_ready, req1_ready,
        input  tx_start, tx_byte, rx_owned,
        input  busy, done, done_id, err, err_code, resp
    );
endinterface

// File: rtl/ps2_cmd_arbiter.sv
// ---------------------------------------------------------------------------
// ps2_cmd_arbiter
// Shares one PS/2 host-to-device byte link between two command requesters.
// A granted request sends its command byte (and optional argument byte),
// checks each for ACK 0xFA, retries on 0xFE up to RETRIES times, aborts on
// 0xFC or on a per-byte timeout, collects up to 3 response bytes and then
// pulses done with an error code.
//
// Ports:
//   clk      28 MHz clock
//   _reset   asynchronous active-low reset
//   clk7_en  clock enable; all state advances only when high
//   bus      ps2_cmd_arbiter_if.slave (requests, tx/rx byte link, status)
//
// All outputs are registered; pulses last exactly one enable cycle.
// ---------------------------------------------------------------------------
module ps2_cmd_arbiter #(
    parameter int TOUT_W  = 16,
    parameter int RETRIES = 3
) (
    input  logic              clk,
    input  logic              _reset,
    input  logic              clk7_en,
    ps2_cmd_arbiter_if.slave  bus
);

    // retry counter is at least 2 bits so the width arithmetic stays valid
    localparam int RW = ($clog2(RETRIES + 1) < 2) ? 2 : $clog2(RETRIES + 1);
    localparam logic [RW-1:0]     RETRY_MAX = RW'(RETRIES);
    localparam logic [RW-1:0]     RETRY_ONE = RW'(1);
    localparam logic [TOUT_W-1:0] TOUT_ALL  = {TOUT_W{1'b1}};
    localparam logic [TOUT_W-1:0] TOUT_ONE  = TOUT_W'(1);
    localparam logic [TOUT_W-1:0] TOUT_ZERO = {TOUT_W{1'b0}};

    localparam logic [1:0] CODE_OK      = 2'b00;
    localparam logic [1:0] CODE_TIMEOUT = 2'b01;
    localparam logic [1:0] CODE_RESEND  = 2'b10;
    localparam logic [1:0] CODE_DEVFAIL = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SEND = 3'd1,
        S_WTX  = 3'd2,
        S_ACK  = 3'd3,
        S_RESP = 3'd4,
        S_FIN  = 3'd5
    } state_t;

    state_t state_r, state_s;
    logic [1:0] fin_code_s;

    // latched request and transaction bookkeeping
    logic [7:0]        cmd_r, cmd_s;
    logic [7:0]        arg_r, arg_s;
    logic              has_arg_r, has_arg_s;
    logic [1:0]        rxlen_r, rxlen_s;
    logic              id_r, id_s;
    logic              last_r, last_s;     // id granted last (round robin)
    logic              phase_r, phase_s;   // 0 = command byte, 1 = argument byte
    logic [RW-1:0]     retry_r, retry_s;
    logic [TOUT_W-1:0] tout_r, tout_s;
    logic [1:0]        rxcnt_r, rxcnt_s;
    logic [23:0]       resp_r, resp_s;

    // registered outputs
    logic       ready0_r, ready0_s;
    logic       ready1_r, ready1_s;
    logic       tx_start_r, tx_start_s;
    logic [7:0] tx_byte_r, tx_byte_s;
    logic       busy_r, busy_s;
    logic       done_r, done_s;
    logic       done_id_r, done_id_s;
    logic       err_r, err_s;
    logic [1:0] err_code_r, err_code_s;

    // event decode
    logic grant0_s, grant1_s, grant_s;
    logic rx_fa_s, rx_fe_s, rx_fc_s, tout_hit_s;

    assign grant0_s   = (state_r == S_IDLE) && bus.req0_valid && (!bus.req1_valid || last_r);
    assign grant1_s   = (state_r == S_IDLE) && bus.req1_valid && (!bus.req0_valid || !last_r);
    assign grant_s    = grant0_s || grant1_s;
    assign rx_fa_s    = bus.rx_valid && (bus.rx_byte == 8'hFA);
    assign rx_fe_s    = bus.rx_valid && (bus.rx_byte == 8'hFE);
    assign rx_fc_s    = bus.rx_valid && (bus.rx_byte == 8'hFC);
    assign tout_hit_s = (tout_r == TOUT_ALL);

    // State register: advances only on enable cycles.
    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            state_r <= S_IDLE;
        end else if (clk7_en) begin
            state_r <= state_s;
        end
    end

    // Next-state logic plus the completion code carried into FIN.
    // A received byte or tx_done is checked before the timeout so it wins.
    always_comb begin
        state_s    = state_r;
        fin_code_s = CODE_OK;
        case (state_r)
            S_IDLE: begin
                if (grant_s) state_s = S_SEND;
                else         state_s = S_IDLE;
            end
            S_SEND: state_s = S_WTX;
            S_WTX: begin
                if (bus.tx_done) begin
                    state_s = S_ACK;
                end else if (tout_hit_s) begin
                    state_s    = S_FIN;
                    fin_code_s = CODE_TIMEOUT;
                end else begin
                    state_s = S_WTX;
                end
            end
            S_ACK: begin
                if (rx_fa_s) begin
                    if (!phase_r && has_arg_r) state_s = S_SEND;
                    else if (rxlen_r != 2'd0)  state_s = S_RESP;
                    else                       state_s = S_FIN;
                end else if (rx_fe_s) begin
                    if (retry_r < RETRY_MAX) begin
                        state_s = S_SEND;
                    end else begin
                        state_s    = S_FIN;
                        fin_code_s = CODE_RESEND;
                    end
                end else if (rx_fc_s) begin
                    state_s    = S_FIN;
                    fin_code_s = CODE_DEVFAIL;
                end else if (bus.rx_valid) begin
                    state_s = S_ACK;            // stray stream byte
                end else if (tout_hit_s) begin
                    state_s    = S_FIN;
                    fin_code_s = CODE_TIMEOUT;
                end else begin
                    state_s = S_ACK;
                end
            end
            S_RESP: begin
                if (bus.rx_valid) begin
                    if ((rxcnt_r + 2'd1) == rxlen_r) state_s = S_FIN;
                    else                             state_s = S_RESP;
                end else if (tout_hit_s) begin
                    state_s    = S_FIN;
                    fin_code_s = CODE_TIMEOUT;
                end else begin
                    state_s = S_RESP;
                end
            end
            S_FIN:   state_s = S_IDLE;
            default: state_s = S_IDLE;
        endcase
    end

    // Datapath and output next values; outputs are computed from the next
    // state so each registered pulse lines up with the state it belongs to.
    always_comb begin
        cmd_s     = cmd_r;
        arg_s     = arg_r;
        has_arg_s = has_arg_r;
        rxlen_s   = rxlen_r;
        id_s      = id_r;
        last_s    = last_r;
        phase_s   = phase_r;
        retry_s   = retry_r;
        rxcnt_s   = rxcnt_r;
        resp_s    = resp_r;
        tout_s    = tout_r;
        case (state_r)
            S_IDLE: begin
                tout_s = TOUT_ZERO;
                if (grant_s) begin
                    id_s      = grant1_s;
                    last_s    = grant1_s;
                    cmd_s     = grant1_s ? bus.req1_cmd     : bus.req0_cmd;
                    arg_s     = grant1_s ? bus.req1_arg     : bus.req0_arg;
                    has_arg_s = grant1_s ? bus.req1_has_arg : bus.req0_has_arg;
                    rxlen_s   = grant1_s ? bus.req1_rxlen   : bus.req0_rxlen;
                    phase_s   = 1'b0;
                    retry_s   = {RW{1'b0}};
                    rxcnt_s   = 2'd0;
                    resp_s    = 24'h000000;
                end else begin
                    id_s = id_r;
                end
            end
            S_SEND: tout_s = TOUT_ZERO;
            S_WTX: begin
                if (bus.tx_done)      tout_s = TOUT_ZERO;
                else if (!tout_hit_s) tout_s = tout_r + TOUT_ONE;
                else                  tout_s = tout_r;
            end
            S_ACK: begin
                if (rx_fa_s) begin
                    tout_s  = TOUT_ZERO;
                    retry_s = {RW{1'b0}};
                    if (!phase_r && has_arg_r) phase_s = 1'b1;
                    else                       phase_s = phase_r;
                end else if (rx_fe_s) begin
                    tout_s = TOUT_ZERO;
                    if (retry_r < RETRY_MAX) retry_s = retry_r + RETRY_ONE;
                    else                     retry_s = retry_r;
                end else if (!tout_hit_s) begin
                    tout_s = tout_r + TOUT_ONE;
                end else begin
                    tout_s = tout_r;
                end
            end
            S_RESP: begin
                if (bus.rx_valid) begin
                    tout_s  = TOUT_ZERO;
                    rxcnt_s = rxcnt_r + 2'd1;
                    case (rxcnt_r)
                        2'd0:    resp_s[7:0]   = bus.rx_byte;
                        2'd1:    resp_s[15:8]  = bus.rx_byte;
                        2'd2:    resp_s[23:16] = bus.rx_byte;
                        default: resp_s        = resp_r;
                    endcase
                end else if (!tout_hit_s) begin
                    tout_s = tout_r + TOUT_ONE;
                end else begin
                    tout_s = tout_r;
                end
            end
            S_FIN:   tout_s = TOUT_ZERO;
            default: tout_s = TOUT_ZERO;
        endcase

        ready0_s   = grant0_s;
        ready1_s   = grant1_s;
        tx_start_s = (state_s == S_SEND);
        busy_s     = (state_s != S_IDLE);
        done_s     = (state_s == S_FIN);
        if (state_s == S_SEND) tx_byte_s = phase_s ? arg_s : cmd_s;
        else                   tx_byte_s = tx_byte_r;
        if (state_s == S_FIN) begin
            err_code_s = fin_code_s;
            err_s      = (fin_code_s != CODE_OK);
            done_id_s  = id_s;
        end else begin
            err_code_s = CODE_OK;
            err_s      = 1'b0;
            done_id_s  = 1'b0;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            cmd_r      <= 8'h00;
            arg_r      <= 8'h00;
            has_arg_r  <= 1'b0;
            rxlen_r    <= 2'd0;
            id_r       <= 1'b0;
            last_r     <= 1'b1;        // requester 0 wins the first tie
            phase_r    <= 1'b0;
            retry_r    <= {RW{1'b0}};
            rxcnt_r    <= 2'd0;
            resp_r     <= 24'h000000;
            tout_r     <= TOUT_ZERO;
            ready0_r   <= 1'b0;
            ready1_r   <= 1'b0;
            tx_start_r <= 1'b0;
            tx_byte_r  <= 8'h00;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            done_id_r  <= 1'b0;
            err_r      <= 1'b0;
            err_code_r <= 2'b00;
        end else if (clk7_en) begin
            cmd_r      <= cmd_s;
            arg_r      <= arg_s;
            has_arg_r  <= has_arg_s;
            rxlen_r    <= rxlen_s;
            id_r       <= id_s;
            last_r     <= last_s;
            phase_r    <= phase_s;
            retry_r    <= retry_s;
            rxcnt_r    <= rxcnt_s;
            resp_r     <= resp_s;
            tout_r     <= tout_s;
            ready0_r   <= ready0_s;
            ready1_r   <= ready1_s;
            tx_start_r <= tx_start_s;
            tx_byte_r  <= tx_byte_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
            done_id_r  <= done_id_s;
            err_r      <= err_s;
            err_code_r <= err_code_s;
        end
    end

    assign bus.req0_ready = ready0_r;
    assign bus.req1_ready = ready1_r;
    assign bus.tx_start   = tx_start_r;
    assign bus.tx_byte    = tx_byte_r;
    assign bus.rx_owned   = busy_r;
    assign bus.busy       = busy_r;
    assign bus.done       = done_r;
    assign bus.done_id    = done_id_r;
    assign bus.err        = err_r;
    assign bus.err_code   = err_code_r;
    assign bus.resp       = resp_r;

endmodule
